// File: rtl/log2_share_arbiter.sv
// Round-robin front end that lets several requesters share one pipelined
// log2 unit. Each issued operand leaves its requester index in a tag FIFO;
// the in-order result stream from the unit pops that tag to route the
// response back to the right requester.
module log2_share_arbiter #(
  parameter int    BITS         = 16,
  parameter string PRECISION    = "HALF",
  parameter int    REQUESTERS   = 4,
  parameter int    MAX_INFLIGHT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQUESTERS-1:0]      req_valid,
  input  logic [REQUESTERS*BITS-1:0] req_data,
  output logic [REQUESTERS-1:0]      req_ready,
  output logic                       unit_in_valid,
  output logic [BITS-1:0]            unit_a,
  input  logic                       unit_out_valid,
  input  logic [BITS-1:0]            unit_c,
  output logic [REQUESTERS-1:0]      resp_valid,
  output logic [BITS-1:0]            resp_data,
  input  logic                       drain,
  output logic                       drain_done,
  output logic                       err_orphan,
  output logic [1:0]                 dbg_state
);

  localparam int TW = $clog2(REQUESTERS);
  localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_INFLIGHT);
  localparam logic [TW-1:0] LAST_REQ = TW'(REQUESTERS - 1);

  // Elaboration-time sanity on the configuration.
  if (REQUESTERS < 2 || REQUESTERS > 8) begin : g_bad_requesters
    $error("REQUESTERS must be in 2..8");
  end
  if ((MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0 || MAX_INFLIGHT < 2) begin : g_bad_depth
    $error("MAX_INFLIGHT must be a power of two, at least 2");
  end
  if (PRECISION == "") begin : g_bad_precision
    $error("PRECISION must name the shared unit's float format");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  state_t          state;
  logic [TW-1:0]   p;
  logic [TW-1:0]   tag_mem [MAX_INFLIGHT];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic                  grant_any;
  logic [TW-1:0]         grant_idx;
  logic [BITS-1:0]       issue_a;
  logic                  push;
  logic                  pop;
  logic                  orphan;
  logic [TW-1:0]         pop_tag;
  logic [REQUESTERS-1:0] pop_onehot;

  assign dbg_state = state;

  // Handshake: a requester transfers in a cycle where both its req_valid and
  // req_ready are high. req_ready is one-hot, depends combinationally on
  // req_valid, and never depends on req_ready elsewhere; unit and response
  // strobes carry no backpressure.

  // Round-robin grant starting at p; a pop in the same cycle does not free room.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    if (!rst && state == ST_RUN && count < MAX_CNT) begin
      for (int k = 0; k < REQUESTERS; k++) begin
        idx = (int'(p) + k) % REQUESTERS;
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = TW'(idx);
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  // Tag FIFO control; an empty FIFO with a same-cycle push bypasses the new tag.
  always_comb begin
    issue_a    = req_data[int'(grant_idx)*BITS +: BITS];
    push       = grant_any;
    pop        = unit_out_valid && (count != '0 || push);
    orphan     = unit_out_valid && !pop;
    pop_tag    = (count == '0) ? grant_idx : tag_mem[rd_ptr];
    pop_onehot = '0;
    pop_onehot[pop_tag] = 1'b1;
  end

  // Tag storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  // Pointer, issue, response, error and drain-FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      p             <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      unit_in_valid <= 1'b0;
      unit_a        <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      drain_done    <= 1'b0;
      err_orphan    <= 1'b0;
    end else begin
      unit_in_valid <= push;
      if (push) begin
        unit_a <= issue_a;
        p      <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      resp_valid <= pop ? pop_onehot : '0;
      if (pop) resp_data <= unit_c;
      if (orphan) err_orphan <= 1'b1;

      case (state)
        ST_RUN: begin
          if (drain) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain) begin
            state <= ST_RUN;
          end else if (count == '0) begin
            state      <= ST_IDLE;
            drain_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!drain) begin
            state      <= ST_RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
